// File: rtl/pattern_chk_pkg.sv
// Shared state encoding and default sizing for the loopback RX pattern checker.
package pattern_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_SEED,
    ST_HUNT,
    ST_LOCKED
  } chk_state_e;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_START_DLY  = 9;
  localparam int unsigned DEF_LOCK_CNT   = 16;
  localparam int unsigned DEF_UNLOCK_CNT = 4;
  localparam int unsigned DEF_ERR_W      = 16;
  localparam int unsigned DLY_W          = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = &cnt_q;

endmodule

// File: rtl/pattern_chk_sync.sv
// RX incrementing-pattern checker: start-up delay, self-seed, lock hunt and
// saturating error count while locked.
module pattern_chk_sync
  import pattern_chk_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned START_DLY  = DEF_START_DLY,
  parameter int unsigned LOCK_CNT   = DEF_LOCK_CNT,
  parameter int unsigned UNLOCK_CNT = DEF_UNLOCK_CNT,
  parameter int unsigned ERR_W      = DEF_ERR_W
) (
  input  logic              rx_clk_i,
  input  logic              pattern_chk_n_i,
  input  logic              rx_ready_i,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              clr_err_i,
  output logic              start_chk_o,
  output logic              locked_o,
  output logic              err_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic              err_sat_o
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

  chk_state_e        state_q;
  logic [DLY_W-1:0]  dly_q;
  logic [MW-1:0]     match_q;
  logic [BW-1:0]     bad_q;
  logic [DATA_W-1:0] exp_q;
  logic              start_q, locked_q, err_q;

  logic [DATA_W-1:0] data_inc_d, exp_inc_d;
  logic              hit_d, word_d, mis_d;

  always_comb begin
    data_inc_d = rx_data_i + DATA_ONE;
    exp_inc_d  = exp_q + DATA_ONE;
    hit_d      = (rx_data_i == exp_q);
    word_d     = rx_ready_i && rx_valid_i;
    mis_d      = word_d && (state_q == ST_LOCKED) && !hit_d;
  end

  always_ff @(posedge rx_clk_i) begin
    if (!pattern_chk_n_i) begin
      state_q  <= ST_IDLE;
      dly_q    <= '0;
      match_q  <= '0;
      bad_q    <= '0;
      exp_q    <= '0;
      start_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= mis_d;
      if (!rx_ready_i) begin
        state_q  <= ST_IDLE;
        dly_q    <= '0;
        match_q  <= '0;
        bad_q    <= '0;
        start_q  <= 1'b0;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          // The entry edge counts as the first delay edge.
          ST_IDLE: begin
            state_q <= ST_DELAY;
            dly_q   <= DLY_W'(1);
          end
          ST_DELAY: begin
            if (dly_q == DLY_W'(START_DLY)) begin
              state_q <= ST_SEED;
              start_q <= 1'b1;
            end else begin
              dly_q <= dly_q + DLY_W'(1);
            end
          end
          ST_SEED: begin
            if (rx_valid_i) begin
              exp_q   <= data_inc_d;
              match_q <= '0;
              state_q <= ST_HUNT;
            end
          end
          ST_HUNT: begin
            if (rx_valid_i) begin
              if (hit_d) begin
                exp_q   <= exp_inc_d;
                match_q <= match_q + MW'(1);
                if (match_q + MW'(1) == MW'(LOCK_CNT)) begin
                  state_q  <= ST_LOCKED;
                  locked_q <= 1'b1;
                  bad_q    <= '0;
                end
              end else begin
                exp_q   <= data_inc_d;
                match_q <= '0;
              end
            end
          end
          ST_LOCKED: begin
            if (rx_valid_i) begin
              if (hit_d) begin
                exp_q <= exp_inc_d;
                bad_q <= '0;
              end else if (bad_q + BW'(1) == BW'(UNLOCK_CNT)) begin
                state_q  <= ST_HUNT;
                locked_q <= 1'b0;
                exp_q    <= data_inc_d;
                match_q  <= '0;
                bad_q    <= '0;
              end else begin
                exp_q <= exp_inc_d;
                bad_q <= bad_q + BW'(1);
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk_i   (rx_clk_i),
    .rst_n_i (pattern_chk_n_i),
    .inc_i   (mis_d),
    .clr_i   (clr_err_i),
    .cnt_o   (err_cnt_o),
    .sat_o   (err_sat_o)
  );

  assign start_chk_o = start_q;
  assign locked_o    = locked_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_pattern_chk_sync.sv
// Directed vector bench for pattern_chk_sync: default instance (A) and a
// 2-bit error counter instance (B) for saturation and clear priority.
module tb_pattern_chk_sync;

  typedef struct {
    bit          rst_n;
    bit          ready;
    bit          valid;
    logic [31:0] data;
    bit          clr;
    bit          start;
    bit          locked;
    bit          err;
    logic [15:0] cnt;
    bit          sat;
  } vec_t;

  logic        clk;
  logic        a_rst_n, a_ready, a_valid, a_clr;
  logic [31:0] a_data;
  logic        a_start, a_locked, a_err, a_sat;
  logic [15:0] a_cnt;
  logic        b_rst_n, b_ready, b_valid, b_clr;
  logic [31:0] b_data;
  logic        b_start, b_locked, b_err, b_sat;
  logic [1:0]  b_cnt;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  vec_t ta[$];
  vec_t tb[$];

  pattern_chk_sync dut_a (
    .rx_clk_i        (clk),
    .pattern_chk_n_i (a_rst_n),
    .rx_ready_i      (a_ready),
    .rx_valid_i      (a_valid),
    .rx_data_i       (a_data),
    .clr_err_i       (a_clr),
    .start_chk_o     (a_start),
    .locked_o        (a_locked),
    .err_o           (a_err),
    .err_cnt_o       (a_cnt),
    .err_sat_o       (a_sat)
  );

  pattern_chk_sync #(.ERR_W(2)) dut_b (
    .rx_clk_i        (clk),
    .pattern_chk_n_i (b_rst_n),
    .rx_ready_i      (b_ready),
    .rx_valid_i      (b_valid),
    .rx_data_i       (b_data),
    .clr_err_i       (b_clr),
    .start_chk_o     (b_start),
    .locked_o        (b_locked),
    .err_o           (b_err),
    .err_cnt_o       (b_cnt),
    .err_sat_o       (b_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int r, int rdy, int vld, logic [31:0] d, int clr,
                              int st, int lk, int er, int unsigned cnt, int sat);
    vec_t v;
    v.rst_n  = (r != 0);
    v.ready  = (rdy != 0);
    v.valid  = (vld != 0);
    v.data   = d;
    v.clr    = (clr != 0);
    v.start  = (st != 0);
    v.locked = (lk != 0);
    v.err    = (er != 0);
    v.cnt    = 16'(cnt);
    v.sat    = (sat != 0);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic run_vec(input vec_t v, input bit use_b, input int idx);
    string tag;
    @(negedge clk);
    if (!use_b) begin
      a_rst_n = v.rst_n; a_ready = v.ready; a_valid = v.valid; a_data = v.data; a_clr = v.clr;
    end else begin
      b_rst_n = v.rst_n; b_ready = v.ready; b_valid = v.valid; b_data = v.data; b_clr = v.clr;
    end
    @(posedge clk);
    #1;
    tag = $sformatf("%s[%0d]", use_b ? "B" : "A", idx);
    if (!use_b) begin
      chk({tag, " start"},  {31'b0, a_start},  {31'b0, v.start});
      chk({tag, " locked"}, {31'b0, a_locked}, {31'b0, v.locked});
      chk({tag, " err"},    {31'b0, a_err},    {31'b0, v.err});
      chk({tag, " cnt"},    {16'b0, a_cnt},    {16'b0, v.cnt});
      chk({tag, " sat"},    {31'b0, a_sat},    {31'b0, v.sat});
    end else begin
      chk({tag, " start"},  {31'b0, b_start},  {31'b0, v.start});
      chk({tag, " locked"}, {31'b0, b_locked}, {31'b0, v.locked});
      chk({tag, " err"},    {31'b0, b_err},    {31'b0, v.err});
      chk({tag, " cnt"},    {30'b0, b_cnt},    {16'b0, v.cnt});
      chk({tag, " sat"},    {31'b0, b_sat},    {31'b0, v.sat});
    end
  endtask

  task automatic add_startup(input bit to_b, input int unsigned cnt);
    // Edge 0 is the first edge sampling rx_ready_i high; start_chk_o rises after edge 9.
    for (int unsigned k = 0; k < 10; k++) begin
      if (!to_b) ta.push_back(mk(1, 1, 0, 32'h0, 0, (k == 9) ? 1 : 0, 0, 0, cnt, 0));
      else       tb.push_back(mk(1, 1, 0, 32'h0, 0, (k == 9) ? 1 : 0, 0, 0, cnt, 0));
    end
  endtask

  initial begin
    a_rst_n = 1'b0; a_ready = 1'b0; a_valid = 1'b0; a_data = '0; a_clr = 1'b0;
    b_rst_n = 1'b0; b_ready = 1'b0; b_valid = 1'b0; b_data = '0; b_clr = 1'b0;

    // ---------------- instance A table ----------------
    ta.push_back(mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
    ta.push_back(mk(0, 1, 1, 32'h5, 1, 0, 0, 0, 0, 0));
    add_startup(1'b0, 0);
    ta.push_back(mk(1, 1, 1, 32'h100, 0, 1, 0, 0, 0, 0));
    for (int unsigned i = 1; i < 16; i++) begin
      ta.push_back(mk(1, 1, 1, 32'h100 + i, 0, 1, 0, 0, 0, 0));
      if (i == 5) ta.push_back(mk(1, 1, 0, 32'hDEAD, 0, 1, 0, 0, 0, 0));
    end
    ta.push_back(mk(1, 1, 1, 32'h110, 0, 1, 1, 0, 0, 0));
    for (int unsigned i = 32'h111; i < 32'h120; i++)
      ta.push_back(mk(1, 1, 1, i, 0, 1, 1, 0, 0, 0));
    ta.push_back(mk(1, 1, 1, 32'h1FF, 0, 1, 1, 1, 1, 0));
    ta.push_back(mk(1, 1, 1, 32'h121, 0, 1, 1, 0, 1, 0));
    ta.push_back(mk(1, 1, 1, 32'h122, 0, 1, 1, 0, 1, 0));
    ta.push_back(mk(1, 1, 0, 32'hBAD, 0, 1, 1, 0, 1, 0));
    ta.push_back(mk(1, 1, 1, 32'h500, 0, 1, 1, 1, 2, 0));
    ta.push_back(mk(1, 1, 1, 32'h600, 0, 1, 1, 1, 3, 0));
    ta.push_back(mk(1, 1, 1, 32'h700, 0, 1, 1, 1, 4, 0));
    ta.push_back(mk(1, 1, 1, 32'h800, 0, 1, 0, 1, 5, 0));
    for (int unsigned i = 32'h801; i < 32'h810; i++)
      ta.push_back(mk(1, 1, 1, i, 0, 1, 0, 0, 5, 0));
    ta.push_back(mk(1, 1, 1, 32'h810, 0, 1, 1, 0, 5, 0));
    ta.push_back(mk(1, 0, 1, 32'h811, 0, 0, 0, 0, 5, 0));
    ta.push_back(mk(1, 0, 0, 32'h0, 0, 0, 0, 0, 5, 0));
    add_startup(1'b0, 5);
    ta.push_back(mk(1, 1, 1, 32'h12345678, 0, 1, 0, 0, 5, 0));
    ta.push_back(mk(1, 1, 1, 32'h12345679, 0, 1, 0, 0, 5, 0));
    ta.push_back(mk(1, 1, 1, 32'hFFFFFFDF, 0, 1, 0, 0, 5, 0));
    for (int unsigned i = 0; i < 16; i++)
      ta.push_back(mk(1, 1, 1, 32'hFFFFFFE0 + i, 0, 1, (i == 15) ? 1 : 0, 0, 5, 0));
    for (int unsigned i = 0; i < 19; i++)
      ta.push_back(mk(1, 1, 1, 32'hFFFFFFF0 + i, 0, 1, 1, 0, 5, 0));
    ta.push_back(mk(1, 0, 1, 32'h77, 0, 0, 0, 0, 5, 0));

    // ---------------- instance B table (ERR_W=2) ----------------
    tb.push_back(mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
    add_startup(1'b1, 0);
    tb.push_back(mk(1, 1, 1, 32'h0, 0, 1, 0, 0, 0, 0));
    for (int unsigned i = 1; i < 17; i++)
      tb.push_back(mk(1, 1, 1, i, 0, 1, (i == 16) ? 1 : 0, 0, 0, 0));
    tb.push_back(mk(1, 1, 1, 32'hAAAA, 0, 1, 1, 1, 1, 0));
    tb.push_back(mk(1, 1, 1, 32'd18,   0, 1, 1, 0, 1, 0));
    tb.push_back(mk(1, 1, 1, 32'hAAAA, 0, 1, 1, 1, 2, 0));
    tb.push_back(mk(1, 1, 1, 32'd20,   0, 1, 1, 0, 2, 0));
    tb.push_back(mk(1, 1, 1, 32'hAAAA, 0, 1, 1, 1, 3, 1));
    tb.push_back(mk(1, 1, 1, 32'd22,   0, 1, 1, 0, 3, 1));
    tb.push_back(mk(1, 1, 1, 32'hAAAA, 0, 1, 1, 1, 3, 1));
    tb.push_back(mk(1, 1, 1, 32'd24,   0, 1, 1, 0, 3, 1));
    tb.push_back(mk(1, 1, 1, 32'hAAAA, 0, 1, 1, 1, 3, 1));
    tb.push_back(mk(1, 1, 1, 32'd26,   0, 1, 1, 0, 3, 1));
    tb.push_back(mk(1, 1, 1, 32'hAAAA, 1, 1, 1, 1, 0, 0));
    tb.push_back(mk(1, 1, 1, 32'd28,   0, 1, 1, 0, 0, 0));
    tb.push_back(mk(1, 1, 1, 32'hAAAA, 0, 1, 1, 1, 1, 0));
    tb.push_back(mk(0, 1, 1, 32'hAAAA, 1, 0, 0, 0, 0, 0));

    foreach (ta[i]) run_vec(ta[i], 1'b0, i);
    foreach (tb[i]) run_vec(tb[i], 1'b1, i);

    // Hand sequence: rx_ready_i dropping mid-delay restarts the full start-up delay.
    @(negedge clk);
    b_rst_n = 1'b1; b_ready = 1'b1; b_valid = 1'b0; b_clr = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    b_ready = 1'b0;
    @(posedge clk); #1;
    chk("B drop-in-delay start", {31'b0, b_start}, 32'd0);
    @(negedge clk);
    b_ready = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    chk("B restart edge8 start", {31'b0, b_start}, 32'd0);
    @(posedge clk); #1;
    chk("B restart edge9 start", {31'b0, b_start}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
